// File: rtl/apple2_video_pkg.sv
// Shared definitions for the video memory fetcher.
//   ADDR_W_DEF / DATA_W_DEF / MISS_W_DEF : default widths
//   FILL_DEF                             : byte shown when no fetched data is ready
//   fetch_state_t                        : fetcher FSM states
package apple2_video_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int MISS_W_DEF = 8;
  localparam logic [7:0] FILL_DEF = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count up by one (holds at all-ones)
//   clr        : synchronous clear, wins over inc
//   count      : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                    count_d = '0;
    else if (inc && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/video_mem_fetcher.sv
// Fetches one video byte per 1 MHz cycle from the RAM arbiter and presents it
// on Dl at the video shifter load strobe.
//   CLOCK_50, RESET      : system clock, async active-low reset
//   phase0               : 1 MHz phase, low = video half
//   ld194                : shifter load pulse; Dl updates on this edge
//   video_addr           : scan address captured on phase0 fall
//   mem_req/addr/ack/rdata : read handshake to the RAM arbiter
//   Dl                   : video data byte
//   fetch_busy           : request outstanding
//   miss_count/miss_clr  : saturating count of fetches aborted by phase0 rise
module video_mem_fetcher
  import apple2_video_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEF),
  parameter int                MISS_W = MISS_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              phase0,
  input  logic              ld194,
  input  logic [ADDR_W-1:0] video_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] Dl,
  output logic              fetch_busy,
  output logic [MISS_W-1:0] miss_count,
  input  logic              miss_clr
);
  fetch_state_t      state_q, state_d;
  logic              phase0_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              bv_q, bv_d;
  logic [DATA_W-1:0] dl_q, dl_d;
  logic              fall, rise, ack_ok, miss_inc;

  assign fall   = phase0_q & ~phase0;
  assign rise   = ~phase0_q & phase0;
  // Acks outside REQ (including one arriving just after reset) are ignored.
  assign ack_ok = (state_q == REQ) & mem_ack;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    bv_d     = bv_q;
    dl_d     = dl_q;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        addr_d  = video_addr;
        state_d = REQ;
      end
      REQ: begin
        // Ack wins over a coincident rise: data is accepted, no miss.
        if (mem_ack) state_d = IDLE;
        else if (rise) begin
          state_d  = IDLE;
          miss_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A newer ack overwrites an unconsumed buffer.
    if (ack_ok) begin
      buf_d = mem_rdata;
      bv_d  = 1'b1;
    end
    if (ld194) begin
      if (ack_ok) begin
        dl_d = mem_rdata; // bypass: data consumed immediately
        bv_d = 1'b0;
      end else if (bv_q) begin
        dl_d = buf_q;
        bv_d = 1'b0;
      end else begin
        dl_d = FILL;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      phase0_q <= 1'b1; // no false fall right after release
      req_q    <= 1'b0;
      addr_q   <= '0;
      buf_q    <= '0;
      bv_q     <= 1'b0;
      dl_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase0_q <= phase0;
      req_q    <= (state_d == REQ);
      addr_q   <= addr_d;
      buf_q    <= buf_d;
      bv_q     <= bv_d;
      dl_q     <= dl_d;
    end
  end

  sat_counter #(.W(MISS_W)) u_miss (
    .clk   (CLOCK_50),
    .rst_n (RESET),
    .inc   (miss_inc),
    .clr   (miss_clr),
    .count (miss_count)
  );

  assign mem_req    = req_q;
  assign fetch_busy = req_q;
  assign mem_addr   = addr_q;
  assign Dl         = dl_q;
endmodule

// File: tb/tb_video_mem_fetcher.sv
module tb_video_mem_fetcher;
  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b0;
  logic        phase0 = 1'b1, ld194 = 1'b0, mem_ack = 1'b0, miss_clr = 1'b0;
  logic [15:0] video_addr = '0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_req, fetch_busy;
  logic [15:0] mem_addr;
  logic [7:0]  Dl, miss_count;

  int n_pass = 0, n_tot = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  video_mem_fetcher dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .phase0(phase0), .ld194(ld194),
    .video_addr(video_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Dl(Dl),
    .fetch_busy(fetch_busy), .miss_count(miss_count), .miss_clr(miss_clr)
  );

  // Transaction-level reference: one optional outstanding fetch, a one-deep
  // latest-data mailbox, the displayed byte and a miss tally.
  bit          m_p0;
  bit          m_out;
  logic [15:0] m_addr;
  bit          m_has;
  logic [7:0]  m_data;
  logic [7:0]  m_dl;
  int          m_miss;

  task automatic model_reset();
    m_p0 = 1; m_out = 0; m_addr = '0; m_has = 0; m_data = '0; m_dl = '0; m_miss = 0;
  endtask

  task automatic model_edge();
    bit got;
    got = m_out && mem_ack;
    if (m_out) begin
      if (mem_ack) m_out = 0;
      else if (!m_p0 && phase0) begin
        m_out = 0;
        if (m_miss < 255) m_miss++;
      end
    end else if (m_p0 && !phase0) begin
      m_out = 1; m_addr = video_addr;
    end
    if (ld194) begin
      if (got)        begin m_dl = mem_rdata; m_has = 0; end
      else if (m_has) begin m_dl = m_data;    m_has = 0; end
      else m_dl = 8'h00;
    end else if (got) begin
      m_data = mem_rdata; m_has = 1;
    end
    if (miss_clr) m_miss = 0;
    m_p0 = phase0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_model();
    chk("req",   {31'd0, mem_req},    {31'd0, m_out});
    chk("busy",  {31'd0, fetch_busy}, {31'd0, m_out});
    chk("addr",  {16'd0, mem_addr},   {16'd0, m_addr});
    chk("dl",    {24'd0, Dl},         {24'd0, m_dl});
    chk("miss",  {24'd0, miss_count}, 32'(m_miss));
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    @(posedge CLOCK_50); #1;
    chk("rst_req",  {31'd0, mem_req},    32'd0);
    chk("rst_addr", {16'd0, mem_addr},   32'd0);
    chk("rst_dl",   {24'd0, Dl},         32'd0);
    chk("rst_miss", {24'd0, miss_count}, 32'd0);
    RESET = 1'b1;
  endtask

  typedef struct {
    logic p0, ld, ack, clr;
    logic [7:0] rd;
    logic [15:0] va;
    logic req;
    logic [15:0] addr;
    logic [7:0] dl;
    logic [7:0] miss;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // p0 ld ack clr  rd     va        req addr      dl     miss
    tbl[0]  = '{1,0,0,0, 8'h00, 16'h0400, 0, 16'h0000, 8'h00, 8'd0};
    tbl[1]  = '{0,0,0,0, 8'h00, 16'h0400, 1, 16'h0400, 8'h00, 8'd0};
    tbl[2]  = '{0,0,0,0, 8'h00, 16'h0400, 1, 16'h0400, 8'h00, 8'd0};
    tbl[3]  = '{0,0,0,0, 8'h00, 16'h0400, 1, 16'h0400, 8'h00, 8'd0};
    tbl[4]  = '{0,0,1,0, 8'hC1, 16'h0400, 0, 16'h0400, 8'h00, 8'd0};
    tbl[5]  = '{0,1,0,0, 8'h00, 16'h0400, 0, 16'h0400, 8'hC1, 8'd0};
    tbl[6]  = '{1,0,0,0, 8'h00, 16'h0500, 0, 16'h0400, 8'hC1, 8'd0};
    tbl[7]  = '{0,0,0,0, 8'h00, 16'h0500, 1, 16'h0500, 8'hC1, 8'd0};
    tbl[8]  = '{0,0,0,0, 8'h00, 16'h0500, 1, 16'h0500, 8'hC1, 8'd0};
    tbl[9]  = '{1,0,0,0, 8'h00, 16'h0600, 0, 16'h0500, 8'hC1, 8'd1};
    tbl[10] = '{1,1,0,0, 8'h00, 16'h0600, 0, 16'h0500, 8'h00, 8'd1};
    tbl[11] = '{0,0,0,0, 8'h00, 16'h0600, 1, 16'h0600, 8'h00, 8'd1};
    tbl[12] = '{0,1,1,0, 8'h5A, 16'h0600, 0, 16'h0600, 8'h5A, 8'd1};
    tbl[13] = '{1,0,0,0, 8'h00, 16'h0700, 0, 16'h0600, 8'h5A, 8'd1};
    tbl[14] = '{1,1,0,0, 8'h00, 16'h0700, 0, 16'h0600, 8'h00, 8'd1};
    tbl[15] = '{0,0,0,0, 8'h00, 16'h0700, 1, 16'h0700, 8'h00, 8'd1};
    tbl[16] = '{1,0,1,0, 8'h3F, 16'h0800, 0, 16'h0700, 8'h00, 8'd1};
    tbl[17] = '{1,1,0,0, 8'h00, 16'h0800, 0, 16'h0700, 8'h3F, 8'd1};

    phase0 = 1'b1; video_addr = 16'h0400;
    #2;
    do_reset();

    // Directed table: basic fetch, abort, bypass, ack-vs-rise.
    for (int i = 0; i < 18; i++) begin
      phase0 = tbl[i].p0; ld194 = tbl[i].ld; mem_ack = tbl[i].ack;
      miss_clr = tbl[i].clr; mem_rdata = tbl[i].rd; video_addr = tbl[i].va;
      step();
      chk($sformatf("tbl%0d_req", i),  {31'd0, mem_req},    {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), {16'd0, mem_addr},   {16'd0, tbl[i].addr});
      chk($sformatf("tbl%0d_dl", i),   {24'd0, Dl},         {24'd0, tbl[i].dl});
      chk($sformatf("tbl%0d_miss", i), {24'd0, miss_count}, {24'd0, tbl[i].miss});
    end
    ld194 = 0; mem_ack = 0; miss_clr = 0;

    // 300 aborted fetches: counter must stick at all-ones.
    for (int i = 0; i < 300; i++) begin
      phase0 = 1'b0; step();
      phase0 = 1'b1; step();
    end
    chk("sat_ff", {24'd0, miss_count}, 32'hFF);
    // Abort coinciding with clear: clear wins.
    phase0 = 1'b0; step();
    phase0 = 1'b1; miss_clr = 1'b1; step();
    miss_clr = 1'b0;
    chk("clr_abort", {24'd0, miss_count}, 32'h00);

    // Reset mid-fetch drops mem_req without waiting for a clock edge.
    phase0 = 1'b0; video_addr = 16'h1234; step();
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("async_req", {31'd0, mem_req}, 32'd0);
    chk("async_dl",  {24'd0, Dl},      32'd0);
    phase0 = 1'b1;
    @(posedge CLOCK_50); #1;
    RESET = 1'b1;
    step();
    // Stray ack after release: must not fill the buffer.
    mem_ack = 1'b1; mem_rdata = 8'hAA; step();
    mem_ack = 1'b0;
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_dl",  {24'd0, Dl},      32'd0);
    ld194 = 1'b1; step();
    ld194 = 1'b0;
    chk("stray_ld_dl", {24'd0, Dl}, 32'd0);

    // Randomised run against the reference model.
    do_reset();
    begin
      int half;
      half = 0;
      for (int i = 0; i < 3000; i++) begin
        if (half == 0) begin
          phase0 = ~phase0;
          half = $urandom_range(8, 2);
        end
        half--;
        video_addr = 16'($urandom);
        mem_rdata  = 8'($urandom);
        mem_ack    = ($urandom_range(3, 0) == 0);
        ld194      = ($urandom_range(5, 0) == 0);
        miss_clr   = ($urandom_range(60, 0) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
